// File: rtl/multi_pwm_tach.sv
// multi_pwm_tach: NUM_CH double-buffered PWM channels on a shared prescaled
// timebase, plus a TACHIN rising-edge period meter with stall detection.

// One PWM channel: shadow/active period+duty registers, tick-driven counter,
// registered output.
module multi_pwm_tach_lane #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic             en_i,
  input  logic             wr_per_i,
  input  logic             wr_duty_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             pwm_o
);

  logic [WIDTH-1:0] per_sh_q, per_sh_d;
  logic [WIDTH-1:0] duty_sh_q, duty_sh_d;
  logic [WIDTH-1:0] per_act_q, per_act_d;
  logic [WIDTH-1:0] duty_act_q, duty_act_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             pwm_q, pwm_d;

  // Next state: shadow writes, period counting, shadow->active transfer at the boundary.
  always_comb begin
    per_sh_d   = per_sh_q;
    duty_sh_d  = duty_sh_q;
    per_act_d  = per_act_q;
    duty_act_d = duty_act_q;
    cnt_d      = cnt_q;
    if (wr_per_i)  per_sh_d  = wr_data_i;
    if (wr_duty_i) duty_sh_d = wr_data_i;
    if (tick_i) begin
      // A disabled or zero-period channel sits at cnt=0 and keeps loading, so it
      // restarts a fresh period with the latest values once it runs again.
      // Active registers take the pre-write shadow, so a write landing on the
      // wrap cycle is deferred one more period.
      if (!en_i || (per_act_q == '0) || (cnt_q == per_act_q)) begin
        cnt_d      = '0;
        per_act_d  = per_sh_q;
        duty_act_d = duty_sh_q;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
    // cnt never exceeds per_act, so duty>period compares true every count.
    pwm_d = en_i && (cnt_q < duty_act_q);
  end

  // Lane state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      per_sh_q   <= '0;
      duty_sh_q  <= '0;
      per_act_q  <= '0;
      duty_act_q <= '0;
      cnt_q      <= '0;
      pwm_q      <= 1'b0;
    end else begin
      per_sh_q   <= per_sh_d;
      duty_sh_q  <= duty_sh_d;
      per_act_q  <= per_act_d;
      duty_act_q <= duty_act_d;
      cnt_q      <= cnt_d;
      pwm_q      <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

module multi_pwm_tach #(
  parameter int NUM_CH   = 4,
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 10,
  parameter int TACH_W   = 24
) (
  input  logic                                       SYSCLK,
  input  logic                                       SYSRESET,
  input  logic                                       WR_EN,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] WR_CH,
  input  logic                                       WR_SEL,
  input  logic [WIDTH-1:0]                           WR_DATA,
  input  logic [NUM_CH-1:0]                          ENABLE,
  output logic [NUM_CH-1:0]                          PWM,
  input  logic                                       TACHIN,
  output logic [TACH_W-1:0]                          TACH_PERIOD,
  output logic                                       TACH_VALID,
  output logic                                       TACH_STALL
);

  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [TACH_W-1:0] TMAX    = '1;
  localparam logic [TACH_W-1:0] TMAX_M1 = TMAX - TACH_W'(1);

  // ---------------- prescaler ----------------
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  assign tick = (presc_q == PW'(PRESCALE - 1));

  // Free-running tick generator, one tick every PRESCALE cycles.
  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // Prescaler register.
  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) presc_q <= '0;
    else          presc_q <= presc_d;
  end

  // ---------------- PWM lanes ----------------
  logic [NUM_CH-1:0] wr_per, wr_duty;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    // Out-of-range WR_CH matches no lane and is dropped.
    assign wr_per[i]  = WR_EN && !WR_SEL && (WR_CH == CHW'(i));
    assign wr_duty[i] = WR_EN &&  WR_SEL && (WR_CH == CHW'(i));

    multi_pwm_tach_lane #(.WIDTH(WIDTH)) u_lane (
      .clk_i     (SYSCLK),
      .rst_i     (SYSRESET),
      .tick_i    (tick),
      .en_i      (ENABLE[i]),
      .wr_per_i  (wr_per[i]),
      .wr_duty_i (wr_duty[i]),
      .wr_data_i (WR_DATA),
      .pwm_o     (PWM[i])
    );
  end

  // ---------------- tachometer ----------------
  // sync_q[1:0] is the two-flop synchronizer, sync_q[2] the edge-detect history.
  logic [2:0]        sync_q, sync_d;
  logic              tedge;
  logic [TACH_W-1:0] tcnt_q, tcnt_d;
  logic [TACH_W-1:0] per_q, per_d;
  logic              vld_q, vld_d;
  logic              stall_q, stall_d;
  logic              armed_q, armed_d;

  assign tedge = sync_q[1] && !sync_q[2];

  // Tach next state: capture on armed edges, otherwise re-arm; saturating count.
  always_comb begin
    sync_d  = {sync_q[1:0], TACHIN};
    tcnt_d  = tcnt_q;
    per_d   = per_q;
    vld_d   = 1'b0;
    stall_d = stall_q;
    armed_d = armed_q;
    if (tedge) begin
      tcnt_d = '0;
      if (armed_q && !stall_q) begin
        // tcnt counts cycles since the previous edge minus one.
        per_d = tcnt_q + TACH_W'(1);
        vld_d = 1'b1;
      end else begin
        stall_d = 1'b0;
        armed_d = 1'b1;
      end
    end else if (tcnt_q != TMAX) begin
      tcnt_d = tcnt_q + TACH_W'(1);
      if (tcnt_q == TMAX_M1) stall_d = 1'b1;
    end
  end

  // Tach state register.
  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      sync_q  <= '0;
      tcnt_q  <= '0;
      per_q   <= '0;
      vld_q   <= 1'b0;
      stall_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      tcnt_q  <= tcnt_d;
      per_q   <= per_d;
      vld_q   <= vld_d;
      stall_q <= stall_d;
      armed_q <= armed_d;
    end
  end

  assign TACH_PERIOD = per_q;
  assign TACH_VALID  = vld_q;
  assign TACH_STALL  = stall_q;

endmodule

// File: tb/tb_multi_pwm_tach.sv
// Bench for multi_pwm_tach: two parameterizations driven from shared stimulus,
// every cycle compared against a behavioural model, plus directed scenarios.
module tb_multi_pwm_tach;

  logic       gclk = 1'b0;
  logic       rst;
  logic       wr_en, wr_sel, tachin;
  logic [1:0] wr_ch;
  logic [7:0] wr_data;
  logic [3:0] en;

  logic [3:0] pwm_a;
  logic [2:0] pwm_b;
  logic [7:0] tper_a;
  logic [9:0] tper_b;
  logic       tvld_a, tvld_b, tstl_a, tstl_b;

  always #5 gclk = ~gclk;

  multi_pwm_tach #(.NUM_CH(4), .WIDTH(8), .PRESCALE(1), .TACH_W(8)) u_a (
    .SYSCLK(gclk), .SYSRESET(rst), .WR_EN(wr_en), .WR_CH(wr_ch), .WR_SEL(wr_sel),
    .WR_DATA(wr_data), .ENABLE(en), .PWM(pwm_a), .TACHIN(tachin),
    .TACH_PERIOD(tper_a), .TACH_VALID(tvld_a), .TACH_STALL(tstl_a));

  multi_pwm_tach #(.NUM_CH(3), .WIDTH(8), .PRESCALE(3), .TACH_W(10)) u_b (
    .SYSCLK(gclk), .SYSRESET(rst), .WR_EN(wr_en), .WR_CH(wr_ch), .WR_SEL(wr_sel),
    .WR_DATA(wr_data), .ENABLE(en[2:0]), .PWM(pwm_b), .TACHIN(tachin),
    .TACH_PERIOD(tper_b), .TACH_VALID(tvld_b), .TACH_STALL(tstl_b));

  int n_chk = 0, n_err = 0;
  bit chk_en = 1'b0;
  int va, vb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int NCH  [2] = '{4, 3};
  localparam int PS   [2] = '{1, 3};
  localparam int TMAX [2] = '{255, 1023};

  int m_presc[2];
  int m_shp[2][4], m_shd[2][4], m_ap[2][4], m_ad[2][4], m_cnt[2][4];
  bit m_pwm[2][4];
  int m_tcnt[2], m_per[2];
  bit m_arm[2], m_stl[2], m_vld[2];
  bit m_h1, m_h2, m_h3;

  always @(posedge gclk) begin : model
    bit edg, tk;
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_presc[d] = 0; m_tcnt[d] = 0; m_per[d] = 0;
        m_arm[d] = 0; m_stl[d] = 0; m_vld[d] = 0;
        for (int c = 0; c < 4; c++) begin
          m_shp[d][c] = 0; m_shd[d][c] = 0; m_ap[d][c] = 0;
          m_ad[d][c] = 0; m_cnt[d][c] = 0; m_pwm[d][c] = 0;
        end
      end
      m_h1 = 0; m_h2 = 0; m_h3 = 0;
    end else begin
      // TACHIN rise seen after two sync stages.
      edg = m_h2 && !m_h3;
      for (int d = 0; d < 2; d++) begin
        tk = (m_presc[d] == PS[d] - 1);
        m_presc[d] = tk ? 0 : m_presc[d] + 1;
        for (int c = 0; c < NCH[d]; c++) begin
          m_pwm[d][c] = en[c] && (m_cnt[d][c] < m_ad[d][c]);
          if (tk) begin
            if (!en[c] || m_ap[d][c] == 0 || m_cnt[d][c] == m_ap[d][c]) begin
              m_cnt[d][c] = 0;
              m_ap[d][c] = m_shp[d][c];
              m_ad[d][c] = m_shd[d][c];
            end else m_cnt[d][c]++;
          end
          if (wr_en && int'(wr_ch) == c) begin
            if (wr_sel) m_shd[d][c] = int'(wr_data);
            else        m_shp[d][c] = int'(wr_data);
          end
        end
        m_vld[d] = 0;
        if (edg) begin
          if (m_arm[d] && !m_stl[d]) begin
            m_per[d] = m_tcnt[d] + 1;
            m_vld[d] = 1;
          end else begin
            m_arm[d] = 1;
            m_stl[d] = 0;
          end
          m_tcnt[d] = 0;
        end else if (m_tcnt[d] < TMAX[d]) begin
          m_tcnt[d]++;
          if (m_tcnt[d] == TMAX[d]) m_stl[d] = 1;
        end
      end
      m_h3 = m_h2; m_h2 = m_h1; m_h1 = tachin;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge gclk) begin : chker
    logic [3:0] ea;
    logic [2:0] eb;
    if (chk_en) begin
      for (int c = 0; c < 4; c++) ea[c] = m_pwm[0][c];
      for (int c = 0; c < 3; c++) eb[c] = m_pwm[1][c];
      chk("pwmA",  32'(pwm_a),  32'(ea));
      chk("pwmB",  32'(pwm_b),  32'(eb));
      chk("tperA", 32'(tper_a), m_per[0]);
      chk("tperB", 32'(tper_b), m_per[1]);
      chk("tvldA", 32'(tvld_a), 32'(m_vld[0]));
      chk("tvldB", 32'(tvld_b), 32'(m_vld[1]));
      chk("tstlA", 32'(tstl_a), 32'(m_stl[0]));
      chk("tstlB", 32'(tstl_b), 32'(m_stl[1]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic run(input int n);
    repeat (n) begin
      @(negedge gclk);
      va += int'(tvld_a);
      vb += int'(tvld_b);
    end
  endtask

  task automatic wr(input int ch, input int sel, input int data);
    wr_ch = 2'(ch); wr_sel = sel[0]; wr_data = 8'(data); wr_en = 1'b1;
    @(negedge gclk);
    wr_en = 1'b0;
  endtask

  task automatic cnt_hi(input int n, output int ha, output int hb);
    ha = 0; hb = 0;
    repeat (n) begin
      @(negedge gclk);
      ha += int'(pwm_a[0]);
      hb += int'(pwm_b[0]);
    end
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    @(negedge gclk);
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    int ha, hb, k, rise, tleft;
    rst = 1'b1; wr_en = 0; wr_sel = 0; wr_ch = 0; wr_data = 0; en = 0; tachin = 0;
    va = 0; vb = 0;
    repeat (3) @(negedge gclk);
    chk_en = 1'b1;
    chk("rst_pwmA", 32'(pwm_a), 0);
    chk("rst_tperB", 32'(tper_b), 0);
    rst = 1'b0;

    // 1: period 9 duty 3 -> 3 of every 10 ticks high
    wr(0, 0, 9); wr(0, 1, 3); en = 4'b0001;
    run(80);
    cnt_hi(30, ha, hb);
    chk("t1_hiA", ha, 9);
    chk("t1_hiB", hb, 9);

    // 2: mid-period duty change, then a write landing on the wrap
    k = 0;
    while (m_cnt[0][0] != 4 && k < 20) begin @(negedge gclk); k++; end
    chk("t2_mid_wait", 32'(k < 20), 1);
    wr(0, 1, 7);
    run(25);
    cnt_hi(10, ha, hb);
    chk("t2_hi7", ha, 7);
    k = 0;
    while (m_cnt[0][0] != 9 && k < 20) begin @(negedge gclk); k++; end
    chk("t2_wrap_wait", 32'(k < 20), 1);
    wr(0, 1, 3);
    cnt_hi(10, ha, hb);
    chk("t2_deferred", ha, 7);
    cnt_hi(10, ha, hb);
    chk("t2_applied", ha, 3);

    // 3: boundary duties, zero period, disable
    wr(0, 1, 0); run(70); cnt_hi(30, ha, hb);
    chk("t3_d0A", ha, 0); chk("t3_d0B", hb, 0);
    wr(0, 1, 12); run(70); cnt_hi(30, ha, hb);
    chk("t3_d12A", ha, 30); chk("t3_d12B", hb, 30);
    wr(0, 0, 0); wr(0, 1, 1); run(70); cnt_hi(30, ha, hb);
    chk("t3_p0A", ha, 30); chk("t3_p0B", hb, 30);
    en = 4'b0000;
    @(negedge gclk);
    chk("t3_disA", 32'(pwm_a[0]), 0);
    chk("t3_disB", 32'(pwm_b[0]), 0);

    // random traffic, including WR_CH beyond u_b's channel count
    en = 4'hF; tleft = 10;
    for (int i = 0; i < 3000; i++) begin
      wr_en   = ($urandom_range(0, 7) == 0);
      wr_ch   = 2'($urandom_range(0, 3));
      wr_sel  = 1'($urandom_range(0, 1));
      wr_data = 8'($urandom_range(0, 14));
      if ($urandom_range(0, 63) == 0) en = 4'($urandom);
      if (tleft == 0) begin tachin = ~tachin; tleft = $urandom_range(5, 300); end
      else tleft--;
      @(negedge gclk);
    end
    wr_en = 1'b0;

    // 4: 500-cycle tach square wave
    tachin = 1'b0; rst_pulse(); va = 0; vb = 0; rise = 0;
    for (int i = 0; i < 2000; i++) begin
      tachin = ((i % 500) < 250);
      if (i % 500 == 0) rise = i;
      @(negedge gclk);
      if (tvld_b) chk("t4_lat", i + 1 - rise, 3);
      va += int'(tvld_a); vb += int'(tvld_b);
    end
    chk("t4_nvldB", vb, 3);
    chk("t4_perB", 32'(tper_b), 500);
    chk("t4_nvldA", va, 0);
    chk("t4_stlA", 32'(tstl_a), 1);
    chk("t4_stlB", 32'(tstl_b), 0);

    // 5: stall on the 8-bit meter
    tachin = 1'b0; rst_pulse(); va = 0; vb = 0;
    tachin = 1; run(50); tachin = 0; run(70); tachin = 1; run(50);
    chk("t5_perA", 32'(tper_a), 120);
    chk("t5_perB", 32'(tper_b), 120);
    chk("t5_nvldA", va, 1);
    tachin = 0; run(300);
    chk("t5_stlA", 32'(tstl_a), 1);
    chk("t5_holdA", 32'(tper_a), 120);
    chk("t5_stlB", 32'(tstl_b), 0);
    va = 0;
    tachin = 1; run(50);
    chk("t5_clrA", 32'(tstl_a), 0);
    chk("t5_novldA", va, 0);
    tachin = 0; run(50); tachin = 1; run(10);
    chk("t5_per100A", 32'(tper_a), 100);
    chk("t5_vldA", va, 1);

    // 6: reset mid-PWM-high and mid-tach-count, with a write in flight
    en = 4'b0011;
    wr(0, 0, 9); wr(0, 1, 5); run(40);
    k = 0;
    while (pwm_a[0] !== 1'b1 && k < 20) begin @(negedge gclk); k++; end
    chk("t6_hi_seen", 32'(pwm_a[0]), 1);
    rst = 1'b1; wr_en = 1'b1; wr_ch = 2'd1; wr_sel = 1'b1; wr_data = 8'd7;
    @(negedge gclk);
    rst = 1'b0; wr_en = 1'b0;
    chk("t6_pwmA", 32'(pwm_a), 0);
    chk("t6_pwmB", 32'(pwm_b), 0);
    chk("t6_tperA", 32'(tper_a), 0);
    chk("t6_tperB", 32'(tper_b), 0);
    va = 0; vb = 0;
    run(60);
    chk("t6_rearmA", va, 0);
    chk("t6_rearmB", vb, 0);
    chk("t6_pwm_idle", 32'(pwm_a), 0);
    tachin = 0; run(40); tachin = 1; run(10);
    chk("t6_capA", va, 1);
    chk("t6_capB", vb, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
